// File: rtl/gpio_in_capture.sv
// gpio_in_capture: synchronises and debounces board inputs, latches edges and
// exposes data/mask/edge-capture registers on an Avalon-MM slave with a level irq.
module gpio_in_capture #(
    parameter int WIDTH = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int EDGE_TYPE = 0,
    parameter logic [WIDTH-1:0] IDLE_LEVEL = {WIDTH{1'b0}}
) (
    input  logic             FPGA_CLK_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins_in,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    output logic [WIDTH-1:0] stable_out
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1, sync2, stable, irq_mask, edge_cap;
    logic [WIDTH-1:0] flip, edge_evt, w1c;
    logic [CW-1:0]    cnt [WIDTH];
    logic [31:0]      rd_mux;
    logic             unused;

    assign unused = ^avs_writedata;

    always_comb begin
        flip = '0;
        for (int i = 0; i < WIDTH; i++)
            flip[i] = sync2[i] != stable[i] && cnt[i] == LAST;
        edge_evt = EDGE_TYPE == 0 ? flip & sync2 : EDGE_TYPE == 1 ? flip & ~sync2 : flip;
        w1c = avs_write && avs_address == 2'd3 ? avs_writedata[WIDTH-1:0] : '0;
        rd_mux = avs_address == 2'd0 ? 32'(stable) :
                 avs_address == 2'd2 ? 32'(irq_mask) :
                 avs_address == 2'd3 ? 32'(edge_cap) : 32'd0;
    end

    always_ff @(posedge FPGA_CLK_50) begin
        if (reset) begin
            sync1        <= IDLE_LEVEL;
            sync2        <= IDLE_LEVEL;
            stable       <= IDLE_LEVEL;
            irq_mask     <= '0;
            edge_cap     <= '0;
            avs_readdata <= '0;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            sync1  <= pins_in;
            sync2  <= sync1;
            stable <= stable ^ flip;
            // A glitch back to the stable level, or an accepted change, restarts the count
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= sync2[i] == stable[i] || flip[i] ? '0 : cnt[i] + CW'(1);
            if (avs_write && avs_address == 2'd2)
                irq_mask <= avs_writedata[WIDTH-1:0];
            edge_cap <= (edge_cap & ~w1c) | edge_evt;
            if (avs_read)
                avs_readdata <= rd_mux;
        end
    end

    assign irq        = |(edge_cap & irq_mask);
    assign stable_out = stable;
endmodule

// File: tb/tb_gpio_in_capture.sv
// tb_gpio_in_capture: register-map vector table, hand-written debounce/edge/reset
// sequences and a randomized run against a sliding-window reference model.
module tb_gpio_in_capture;
    localparam int D = 4;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  pins = '0;
    logic [W-1:0]  pins2 = 8'hFF;
    logic [1:0]    avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic [31:0]   rd1, rd2;
    logic          irq1, irq2;
    logic [W-1:0]  so1, so2;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    gpio_in_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0), .IDLE_LEVEL(8'h00)) dut (
        .FPGA_CLK_50(clk), .reset(reset), .pins_in(pins), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rd1), .irq(irq1), .stable_out(so1));

    gpio_in_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2), .IDLE_LEVEL(8'hFF)) dut2 (
        .FPGA_CLK_50(clk), .reset(reset), .pins_in(pins2), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rd2), .irq(irq2), .stable_out(so2));

    // Reference model: a bit changes once its last D synchronised samples all disagree with it
    logic [W-1:0] h [0:D];
    logic [W-1:0] m_stable, m_mask, m_cap, flips;
    logic [31:0]  m_rd;

    always @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j <= D; j++) h[j] = '0;
            m_stable = '0;
            m_mask   = '0;
            m_cap    = '0;
            m_rd     = '0;
        end else begin
            flips = '0;
            for (int b = 0; b < W; b++) begin
                flips[b] = 1'b1;
                for (int j = 1; j <= D; j++)
                    if (h[j][b] == m_stable[b]) flips[b] = 1'b0;
            end
            if (avs_read)
                m_rd = avs_address == 2'd0 ? {24'd0, m_stable} :
                       avs_address == 2'd2 ? {24'd0, m_mask} :
                       avs_address == 2'd3 ? {24'd0, m_cap} : 32'd0;
            if (avs_write && avs_address == 2'd2) m_mask = avs_writedata[W-1:0];
            m_cap = (m_cap & ~((avs_write && avs_address == 2'd3) ? avs_writedata[W-1:0] : 8'h00))
                    | (flips & ~m_stable);
            m_stable = m_stable ^ flips;
            for (int j = D; j > 0; j--) h[j] = h[j-1];
            h[0] = pins;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("model_stable", {24'd0, so1}, {24'd0, m_stable});
        check("model_irq", {31'd0, irq1}, {31'd0, |(m_cap & m_mask)});
        check("model_rd", rd1, m_rd);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] d);
        avs_read = rd;
        avs_write = wr;
        avs_address = a;
        avs_writedata = d;
        tick();
        avs_read = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;
    vec_t vt [13];

    initial begin
        vt[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h0,  1'b0};
        vt[1]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h0,  1'b0};
        vt[2]  = '{1'b1, 1'b0, 2'd3, 32'h0,        32'h0,  1'b0};
        vt[3]  = '{1'b1, 1'b0, 2'd1, 32'h0,        32'h0,  1'b0};
        vt[4]  = '{1'b0, 1'b1, 2'd2, 32'hFFFFFFA5, 32'h0,  1'b0};
        vt[5]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'hA5, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 2'd0, 32'hFF,       32'hA5, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h0,  1'b0};
        vt[8]  = '{1'b1, 1'b1, 2'd2, 32'h3C,       32'hA5, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h3C, 1'b0};
        vt[10] = '{1'b1, 1'b1, 2'd1, 32'hFF,       32'h0,  1'b0};
        vt[11] = '{1'b1, 1'b1, 2'd3, 32'hFF,       32'h0,  1'b0};
        vt[12] = '{1'b0, 1'b1, 2'd2, 32'h0,        32'h0,  1'b0};

        do_reset();
        check("reset_irq", {31'd0, irq1}, 32'd0);
        check("reset_stable", {24'd0, so1}, 32'd0);
        for (int v = 0; v < 13; v++) begin
            bus(vt[v].rd, vt[v].wr, vt[v].a, vt[v].wd);
            check($sformatf("vec%0d_rd", v), rd1, vt[v].exp_rd);
            check($sformatf("vec%0d_irq", v), {31'd0, irq1}, {31'd0, vt[v].exp_irq});
        end

        pins[0] = 1'b1;
        ticks(5);
        check("rise_lat5", {31'd0, so1[0]}, 32'd0);
        tick();
        check("rise_lat6", {31'd0, so1[0]}, 32'd1);
        bus(1, 0, 2'd3, 0);
        check("rise_cap", rd1, 32'h01);
        check("rise_irq_masked", {31'd0, irq1}, 32'd0);
        bus(0, 1, 2'd2, 32'h01);
        check("mask_irq", {31'd0, irq1}, 32'd1);

        bus(0, 1, 2'd3, 32'hFF);
        pins[3] = 1'b1;
        ticks(3);
        pins[3] = 1'b0;
        ticks(10);
        check("glitch_stable", {31'd0, so1[3]}, 32'd0);
        bus(1, 0, 2'd3, 0);
        check("glitch_cap", rd1, 32'h0);
        pins[3] = 1'b1;
        ticks(4);
        pins[3] = 1'b0;
        ticks(12);
        bus(1, 0, 2'd3, 0);
        check("pulse_cap", rd1, 32'h08);
        check("pulse_stable", {31'd0, so1[3]}, 32'd0);

        pins = 8'h00;
        do_reset();
        pins = 8'h05;
        ticks(8);
        bus(0, 1, 2'd2, 32'hFF);
        bus(1, 0, 2'd3, 0);
        check("cap05", rd1, 32'h05);
        bus(0, 1, 2'd3, 32'h04);
        bus(1, 0, 2'd3, 0);
        check("w1c_bit2", rd1, 32'h01);
        check("w1c_bit2_irq", {31'd0, irq1}, 32'd1);
        bus(0, 1, 2'd3, 32'h01);
        bus(1, 0, 2'd3, 0);
        check("w1c_all", rd1, 32'h0);
        check("w1c_all_irq", {31'd0, irq1}, 32'd0);
        pins[0] = 1'b0;
        ticks(8);
        pins[0] = 1'b1;
        ticks(5);
        bus(0, 1, 2'd3, 32'h01);
        bus(1, 0, 2'd3, 0);
        check("set_beats_w1c", rd1, 32'h01);

        check("pre_reset_irq", {31'd0, irq1}, 32'd1);
        pins[5] = 1'b1;
        ticks(4);
        pins = 8'h00;
        do_reset();
        check("rst_irq", {31'd0, irq1}, 32'd0);
        check("rst_stable", {24'd0, so1}, 32'd0);
        check("rst_rd", rd1, 32'd0);
        ticks(10);
        bus(1, 0, 2'd3, 0);
        check("rst_no_edge", rd1, 32'h0);
        bus(1, 0, 2'd2, 0);
        check("rst_mask", rd1, 32'h0);

        pins2 = 8'hFF;
        do_reset();
        bus(1, 0, 2'd3, 0);
        check("any_reset_cap", rd2, 32'h0);
        check("any_reset_stable", {24'd0, so2}, 32'hFF);
        pins2[1] = 1'b0;
        ticks(8);
        check("any_press_stable", {24'd0, so2}, 32'hFD);
        bus(1, 0, 2'd3, 0);
        check("any_press_cap", rd2, 32'h02);
        bus(0, 1, 2'd3, 32'h02);
        bus(1, 0, 2'd3, 0);
        check("any_w1c", rd2, 32'h0);
        pins2[1] = 1'b1;
        ticks(8);
        bus(1, 0, 2'd3, 0);
        check("any_release_cap", rd2, 32'h02);
        check("any_irq_masked", {31'd0, irq2}, 32'd0);

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 7) == 0) pins[b] = ~pins[b];
            avs_read = 1'($urandom_range(0, 1));
            avs_write = $urandom_range(0, 3) == 0;
            avs_address = 2'($urandom_range(0, 3));
            avs_writedata = $urandom;
            reset = $urandom_range(0, 499) == 0;
            tick();
        end
        reset = 1'b0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
